store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Memory-stage store buffer: the consumer side of the M-stage data-memory write enable.
- Captures every valid store (opcode 00111) leaving the M stage into a small FIFO, then drains it to the data-memory write port under a ready handshake.
- Forwards buffered data to M-stage loads (opcode 01000) whose address matches, so loads never see stale memory.
- Asserts stall toward the pipeline only when a store arrives and the FIFO cannot accept it.

Parameters:
DEPTH, 4, number of buffer entries; power of two, >= 2
ADDR_WIDTH, 12, data-memory word address width
DATA_WIDTH, 32, store data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
instruction  input  32  M-stage instruction; opcode = instruction[31:27]
valid_M  input  1  M-stage slot holds a real instruction, not a bubble
address  input  ADDR_WIDTH  M-stage effective address
data_in  input  DATA_WIDTH  M-stage store data
stall  output  1  store present but cannot be accepted this cycle
load_hit  output  1  M-stage load matches a buffered store
load_data  output  DATA_WIDTH  forwarded data; valid when load_hit = 1
mem_wren  output  1  head entry valid, write request to dmem
mem_address  output  ADDR_WIDTH  head entry address
mem_data  output  DATA_WIDTH  head entry data
mem_ready  input  1  dmem accepts head write at this rising edge
count  output  clog2(DEPTH+1)  occupied entries
empty  output  1  count == 0

Behaviour:
- Decode:
  - is_store = valid_M & (opcode == 5'b00111).
  - is_load = valid_M & (opcode == 5'b01000).
  - All other opcodes are ignored.
- Reset (async, any time, including mid-drain):
  - head, tail and count go to 0; all entry valid bits clear.
  - mem_wren = 0, stall = 0, load_hit = 0, empty = 1.
  - mem_address, mem_data and load_data go to 0.
  - Any write in flight is abandoned. No memory write may be issued in the cycle reset deasserts.
- Pop:
  - pop = mem_wren & mem_ready.
  - At the edge, the head entry is invalidated and head wraps modulo DEPTH.
- Push:
  - push = is_store & (count < DEPTH | pop).
  - At the edge, {address, data_in} is written at tail; tail wraps modulo DEPTH.
- Stall:
  - stall = is_store & (count == DEPTH) & ~pop. Combinational.
  - The pipeline holds the store; it is retried each cycle.
- Full with simultaneous pop and push:
  - Both occur in the same edge; count stays DEPTH; no stall.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Memory port:
  - mem_wren = ~empty.
  - mem_address and mem_data are driven from the head entry and are stable while mem_ready = 0.
  - Drain order is strictly FIFO.
  - A store pushed at edge N is visible on the memory port no earlier than cycle N+1. There is no bypass from input to memory port.
- Forwarding:
  - Combinational compare of address against every valid entry when is_load = 1.
  - With multiple matches, the youngest entry (closest to tail) wins.
  - An entry popping in the current cycle still counts as valid for forwarding.
  - load_hit = 0 and load_data = 0 when not is_load or no match.
  - A store and a load are never present in the same cycle, since there is a single M slot.
- mem_ready while empty is ignored.

Test Plan:
- Reset mid-drain: 3 stores buffered, mem_ready = 0, assert reset -> count = 0, empty = 1, mem_wren = 0 immediately (before the next edge); no write issued after release.
- Single store, addr 0x010, data 0xDEADBEEF, mem_ready held 1 -> mem_wren = 1 with that addr/data in the cycle after push; count returns 0 after one more edge.
- Fill to 4 with mem_ready = 0, then 5th store -> stall = 1, count = 4. Raise mem_ready the next cycle -> stall = 0, push and pop in the same edge, count stays 4; drain order is addresses 1, 2, 3, 4, 5.
- Stores to 0x020 (0x11111111) then 0x020 (0x22222222), mem_ready = 0, then load 0x020 -> load_hit = 1, load_data = 0x22222222. Load 0x021 -> load_hit = 0, load_data = 0.
- Non-store opcodes (00000, 00101, 01000) and store opcode with valid_M = 0 -> no push; count unchanged.
- Tail wrap: push/pop 10 stores continuously with mem_ready toggling 1,0 -> every store written exactly once, in order, with no loss across the pointer wrap at DEPTH = 4.

Source files
------------

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : M-stage store buffer. Captures valid stores into a small
//               FIFO, drains them in order to the data-memory write port
//               under a ready handshake, and forwards buffered data to
//               matching M-stage loads (youngest match wins).
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  instruction,
    input  logic                         valid_M,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         stall,
    output logic                         load_hit,
    output logic [DATA_WIDTH-1:0]        load_data,
    output logic                         mem_wren,
    output logic [ADDR_WIDTH-1:0]        mem_address,
    output logic [DATA_WIDTH-1:0]        mem_data,
    input  logic                         mem_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int                 C_PTR_W    = $clog2(DEPTH);
    localparam int                 C_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [4:0]         C_OP_STORE = 5'b00111;
    localparam logic [4:0]         C_OP_LOAD  = 5'b01000;
    localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(DEPTH);

    // Entry storage and pointers
    logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [C_PTR_W-1:0]    head_q;
    logic [C_PTR_W-1:0]    head_d;
    logic [C_PTR_W-1:0]    tail_q;
    logic [C_PTR_W-1:0]    tail_d;
    logic [C_CNT_W-1:0]    count_q;
    logic [C_CNT_W-1:0]    count_d;

    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [C_PTR_W-1:0]    w_fwd_idx;
    logic                  w_unused_instr;

    // Only the opcode field matters to this block
    assign w_unused_instr = ^instruction[26:0];

    // Decode the M-stage slot and derive the FIFO handshakes
    always_comb begin
        w_is_store = valid_M & (instruction[31:27] == C_OP_STORE);
        w_is_load  = valid_M & (instruction[31:27] == C_OP_LOAD);
        w_empty    = (count_q == '0);
        w_pop      = ~w_empty & mem_ready;
        // A full buffer still accepts a store when the head drains on the same edge
        w_push     = w_is_store & ((count_q < C_FULL) | w_pop);
        stall      = w_is_store & (count_q == C_FULL) & ~w_pop;
    end

    // Next-state computation for entries, pointers and occupancy
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Pop is applied before push so a full pop+push on the same slot leaves it valid
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + C_PTR_W'(1);
        end
        if (w_push) begin
            addr_d[tail_q]  = address;
            data_d[tail_q]  = data_in;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + C_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_W'(1);
        end
    end

    // State registers with asynchronous clear; an in-flight write is simply dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Load forwarding: scan oldest to youngest so the youngest match is kept
    always_comb begin
        load_hit  = 1'b0;
        load_data = '0;
        w_fwd_idx = '0;
        if (w_is_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_fwd_idx = head_q + C_PTR_W'(i);
                if (valid_q[w_fwd_idx] && (addr_q[w_fwd_idx] == address)) begin
                    load_hit  = 1'b1;
                    load_data = data_q[w_fwd_idx];
                end
            end
        end
    end

    // Memory port presents the head entry; zeroed when nothing is buffered
    always_comb begin
        mem_wren    = ~w_empty;
        mem_address = w_empty ? '0 : addr_q[head_q];
        mem_data    = w_empty ? '0 : data_q[head_q];
        count       = count_q;
        empty       = w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_write_buffer
// Description : Scoreboard bench for store_write_buffer. Accepted stores are
//               queued as they are driven and checked in order as the DUT
//               drains them; occupancy, stall and mem_wren follow a small
//               reference count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    localparam int C_DEPTH = 4;
    localparam int C_AW    = 12;
    localparam int C_DW    = 32;
    localparam logic [4:0] C_OP_ST = 5'b00111;
    localparam logic [4:0] C_OP_LD = 5'b01000;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       instruction;
    logic              valid_M;
    logic [C_AW-1:0]   address;
    logic [C_DW-1:0]   data_in;
    logic              stall;
    logic              load_hit;
    logic [C_DW-1:0]   load_data;
    logic              mem_wren;
    logic [C_AW-1:0]   mem_address;
    logic [C_DW-1:0]   mem_data;
    logic              mem_ready;
    logic [2:0]        count;
    logic              empty;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    int model_cnt = 0;
    bit toggle_en = 1'b0;
    logic [C_AW+C_DW-1:0] sb [$];

    store_write_buffer #(.DEPTH(C_DEPTH), .ADDR_WIDTH(C_AW), .DATA_WIDTH(C_DW)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .valid_M(valid_M),
        .address(address), .data_in(data_in), .stall(stall), .load_hit(load_hit),
        .load_data(load_data), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_data(mem_data), .mem_ready(mem_ready), .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge clock) begin
        logic exp_wren, exp_pop, exp_store, exp_push, exp_stall;
        logic [C_AW+C_DW-1:0] e;
        if (reset) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            exp_wren  = (model_cnt != 0);
            exp_pop   = exp_wren && mem_ready;
            exp_store = valid_M && (instruction[31:27] == C_OP_ST);
            exp_push  = exp_store && ((model_cnt < C_DEPTH) || exp_pop);
            exp_stall = exp_store && (model_cnt == C_DEPTH) && !exp_pop;
            n_tests++;
            if (count !== 3'(model_cnt)) begin
                n_fail++; $display("FAIL mon_count: got %0d expected %0d at %0t", count, model_cnt, $time);
            end
            n_tests++;
            if (mem_wren !== exp_wren) begin
                n_fail++; $display("FAIL mon_wren: got %b expected %b at %0t", mem_wren, exp_wren, $time);
            end
            n_tests++;
            if (stall !== exp_stall) begin
                n_fail++; $display("FAIL mon_stall: got %b expected %b at %0t", stall, exp_stall, $time);
            end
            n_tests++;
            if (empty !== (model_cnt == 0)) begin
                n_fail++; $display("FAIL mon_empty: got %b expected %b at %0t", empty, (model_cnt == 0), $time);
            end
            if (exp_pop) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL mon_underflow: write addr %h with no queued store", mem_address);
                end else begin
                    e = sb.pop_front();
                    n_writes++;
                    if ({mem_address, mem_data} !== e) begin
                        n_fail++;
                        $display("FAIL mon_write: got %h/%h expected %h/%h at %0t",
                                 mem_address, mem_data, e[C_AW+C_DW-1:C_DW], e[C_DW-1:0], $time);
                    end
                end
            end
            if (exp_push) sb.push_back({address, data_in});
            model_cnt = model_cnt + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
        end
    end

    task automatic set_idle();
        valid_M = 1'b0; instruction = '0; address = '0; data_in = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
        if (toggle_en) mem_ready = ~mem_ready;
    endtask

    // Present a store and retry while stalled, bounded
    task automatic do_store(input logic [C_AW-1:0] a, input logic [C_DW-1:0] d);
        logic s;
        s = 1'b1;
        instruction = {C_OP_ST, 27'h0}; valid_M = 1'b1; address = a; data_in = d;
        for (int k = 0; k < 50 && s; k++) begin
            @(negedge clock); s = stall;
            next_cycle();
        end
        if (s) begin
            n_tests++; n_fail++; $display("FAIL store_timeout: addr %h still stalled", a);
        end
        set_idle();
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && !empty; k++) next_cycle();
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_timeout: count %0d expected 0", count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; set_idle();
        #1;
        n_tests++;
        if ({count, empty, mem_wren, stall, load_hit} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_flags: count %0d empty %b wren %b stall %b hit %b expected 0 1 0 0 0",
                               count, empty, mem_wren, stall, load_hit);
        end
        n_tests++;
        if ({mem_address, mem_data, load_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h data %h ldata %h expected 0", mem_address, mem_data, load_data);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        mem_ready = 1'b0;
        do_store(12'h100, 32'h1); do_store(12'h101, 32'h2); do_store(12'h102, 32'h3);
        n_tests++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL rmd_fill: count %0d expected 3", count); end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({count, empty, mem_wren} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL rmd_async: count %0d empty %b wren %b expected 0 1 0", count, empty, mem_wren);
        end
        @(posedge clock); #3;
        reset = 1'b0; mem_ready = 1'b1;
        n_tests++;
        if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL rmd_release: wren %b expected 0", mem_wren); end
        repeat (3) next_cycle();
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        do_store(12'h010, 32'hDEADBEEF);
        n_tests++;
        if ({mem_wren, mem_address, mem_data} !== {1'b1, 12'h010, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_port: wren %b addr %h data %h expected 1 010 deadbeef",
                               mem_wren, mem_address, mem_data);
        end
        next_cycle();
        n_tests++;
        if ({count, empty} !== {3'd0, 1'b1}) begin
            n_fail++; $display("FAIL single_drain: count %0d empty %b expected 0 1", count, empty);
        end
    endtask

    task automatic test_full_stall();
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) do_store(12'(i), 32'hA000_0000 + 32'(i));
        n_tests++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: count %0d expected 4", count); end
        instruction = {C_OP_ST, 27'h0}; valid_M = 1'b1; address = 12'h005; data_in = 32'hA000_0005;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: stall %b expected 1", stall); end
        next_cycle();
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL full_unstall: stall %b expected 0", stall); end
        next_cycle();
        set_idle();
        n_tests++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop: count %0d expected 4", count); end
        drain(20);
    endtask

    task automatic test_forward();
        mem_ready = 1'b0;
        do_store(12'h020, 32'h11111111);
        do_store(12'h020, 32'h22222222);
        instruction = {C_OP_LD, 27'h0}; valid_M = 1'b1; address = 12'h020;
        #1;
        n_tests++;
        if ({load_hit, load_data} !== {1'b1, 32'h22222222}) begin
            n_fail++; $display("FAIL fwd_youngest: hit %b data %h expected 1 22222222", load_hit, load_data);
        end
        address = 12'h021;
        #1;
        n_tests++;
        if ({load_hit, load_data} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL fwd_miss: hit %b data %h expected 0 0", load_hit, load_data);
        end
        instruction = 32'h0; address = 12'h020;
        #1;
        n_tests++;
        if (load_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_nonload: hit %b expected 0", load_hit); end
        set_idle();
        mem_ready = 1'b1;
        drain(20);
        do_store(12'h030, 32'h33333333);
        instruction = {C_OP_LD, 27'h0}; valid_M = 1'b1; address = 12'h030;
        #1;
        n_tests++;
        if ({load_hit, load_data} !== {1'b1, 32'h33333333}) begin
            n_fail++; $display("FAIL fwd_popping: hit %b data %h expected 1 33333333", load_hit, load_data);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_ignored();
        logic [4:0] ops [3];
        ops[0] = 5'b00000; ops[1] = 5'b00101; ops[2] = 5'b01000;
        mem_ready = 1'b0;
        do_store(12'h040, 32'h44444444);
        for (int i = 0; i < 4; i++) begin
            address = 12'h050; data_in = 32'h55555555;
            if (i < 3) begin instruction = {ops[i], 27'h0}; valid_M = 1'b1; end
            else       begin instruction = {C_OP_ST, 27'h0}; valid_M = 1'b0; end
            next_cycle();
            n_tests++;
            if (count !== 3'd1) begin n_fail++; $display("FAIL ignored_%0d: count %0d expected 1", i, count); end
        end
        set_idle();
        mem_ready = 1'b1;
        drain(20);
    endtask

    task automatic test_back_to_back_wrap();
        int w0;
        w0 = n_writes;
        mem_ready = 1'b1; toggle_en = 1'b1;
        for (int i = 0; i < 10; i++) do_store(12'h200 + 12'(i), 32'hC0DE_0000 + 32'(i * 7));
        drain(40);
        toggle_en = 1'b0;
        n_tests++;
        if ((n_writes - w0) != 10 || sb.size() != 0) begin
            n_fail++; $display("FAIL wrap_writes: got %0d writes, %0d left expected 10 and 0", n_writes - w0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_single();
        test_full_stall();
        test_forward();
        test_ignored();
        test_back_to_back_wrap();
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
